// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I encoding constants and types for inst_encoder.
//   fmt_e     - instruction format selector carried on in_fmt
//   state_e   - encoder sequencing states
//   OP_*      - major opcodes for each supported format
//   NOP_INST  - addi x0,x0,0, emitted for an undefined format
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_I_ALU  = 3'd1,
    FMT_I_LOAD = 3'd2,
    FMT_S      = 3'd3,
    FMT_B      = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational RV32I field packer.
// Ports:
//   i_fmt        format code (fmt_e encoding; other values are undefined)
//   i_rd/i_rs1/i_rs2, i_funct3, i_funct7, i_imm  decoded fields
//   o_word       packed 32-bit instruction (NOP for undefined format)
//   o_fmt_err    i_fmt is not a defined format
//   o_range_err  immediate does not fit its format
// Config macro: IMM_RANGE_CHECK_EN enables immediate range checking;
// when undefined the immediate is truncated silently and o_range_err is 0.
module inst_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_fmt_err,
  output logic        o_range_err
);

  fmt_e w_fmt;
  logic w_i_oor;
  logic w_b_oor;

  assign w_fmt = fmt_e'(i_fmt);

`ifdef IMM_RANGE_CHECK_EN
  // 12-bit signed for I/S; B holds a 13-bit even offset.
  assign w_i_oor = ($signed(i_imm) < -32'sd2048) || ($signed(i_imm) > 32'sd2047);
  assign w_b_oor = ($signed(i_imm) < -32'sd4096) || ($signed(i_imm) > 32'sd4094) || i_imm[0];
`else
  logic w_imm_unused;
  assign w_imm_unused = ^i_imm[31:13];
  assign w_i_oor      = 1'b0;
  assign w_b_oor      = 1'b0;
`endif

  always_comb begin
    o_word      = NOP_INST;
    o_fmt_err   = 1'b0;
    o_range_err = 1'b0;
    case (w_fmt)
      FMT_R: begin
        o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
      end
      FMT_I_ALU: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM};
        o_range_err = w_i_oor;
      end
      FMT_I_LOAD: begin
        o_word      = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
        o_range_err = w_i_oor;
      end
      FMT_S: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
        o_range_err = w_i_oor;
      end
      FMT_B: begin
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], OP_BRANCH};
        o_range_err = w_b_oor;
      end
      default: begin
        o_fmt_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: streams decoded RV32I fields into packed instruction words
// with sequential instruction-memory addresses.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, base_addr     begin a batch at base_addr (IDLE only)
//   in_valid/in_ready    input handshake; in_fmt, in_rd, in_rs1, in_rs2,
//                        in_funct3, in_funct7, in_imm fields; in_last ends batch
//   out_valid/out_ready  output handshake; out_inst word at out_addr
//   busy                 batch in progress
//   done                 one-cycle pulse once the final word has drained
//   err                  sticky error (undefined format or bad immediate)
// Config macro: IMM_RANGE_CHECK_EN (see inst_pack).
module inst_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_out_inst;
  logic [31:0] r_out_addr;
  logic        r_out_valid;
  logic        r_err;

  logic        w_accept;
  logic        w_in_ready;
  logic [31:0] w_word;
  logic        w_fmt_err;
  logic        w_range_err;

  inst_pack u_pack (
    .i_fmt       (in_fmt),
    .i_rd        (in_rd),
    .i_rs1       (in_rs1),
    .i_rs2       (in_rs2),
    .i_funct3    (in_funct3),
    .i_funct7    (in_funct7),
    .i_imm       (in_imm),
    .o_word      (w_word),
    .o_fmt_err   (w_fmt_err),
    .o_range_err (w_range_err)
  );

  // The output register can take a new word whenever it is empty or being
  // drained this cycle, giving full throughput with no bubble.
  assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start)                w_state_nxt = ST_RUN;
      ST_RUN:   if (w_accept && in_last)  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_out_valid)         w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_out_inst  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && start) begin
        r_pc  <= base_addr;
        r_err <= 1'b0;
      end
      if (w_accept) begin
        r_out_inst  <= w_word;
        r_out_addr  <= r_pc;
        r_out_valid <= 1'b1;
        r_pc        <= r_pc + 32'd4;
        if (w_fmt_err || w_range_err) r_err <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_inst  = r_out_inst;
  assign out_addr  = r_out_addr;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DRAIN) && !r_out_valid;
  assign err       = r_err;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential RISC-V RV32I instruction encoder: the inverse of the ID-stage immediate generator. Accepts decoded instruction fields (format, registers, funct codes, signed immediate) over a valid/ready stream, packs them into 32-bit instruction words, and emits each word with a sequential instruction-memory address. Used by the bench and boot loader to build instruction-memory images for the pipelined core.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; loads base_addr and enters RUN (honoured in IDLE only)
- base_addr  in  32  address of first emitted word; must be 4-byte aligned
- in_valid / in_ready  in / out  1  input handshake
- in_fmt  in  3  fmt_e: R, I_ALU, I_LOAD, S, B
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed byte immediate
- in_last  in  1  marks final instruction of the batch
- out_valid / out_ready  out / in  1  output handshake
- out_inst  out  32  encoded instruction word
- out_addr  out  32  memory address for out_inst
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last word is accepted downstream
- err  out  1  sticky error flag; cleared by start or rst

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start; pc <= base_addr; err <= 0.
  - RUN -> DRAIN when the in_last beat is accepted.
  - DRAIN -> IDLE when the output holds no valid word; done pulses on that cycle.
- start outside IDLE is ignored.
- in_ready = (state == RUN) && (!out_valid || out_ready).
- On input accept:
  - out_inst <= packed word; out_addr <= pc; pc <= pc + 4.
  - pc wraps modulo 2^32 with no error.
- Packing, opcode taken from in_fmt:
  - R (0110011): funct7 | rs2 | rs1 | funct3 | rd | op
  - I_ALU (0010011) and I_LOAD (0000011): imm[11:0] | rs1 | funct3 | rd | op
  - S (0100011): imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | op
  - B (1100011): imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | op
  - Unused fields are ignored (for example, rs2 for I formats).
- Undefined in_fmt: emit NOP 32'h00000013 and set err. This check is always present.

## Timing
- Latency 1 cycle: the word accepted on edge N is presented on out_* after edge N.
- Throughput is 1 word/cycle when out_ready is held high.
- Simultaneous output drain and input accept in the same cycle is legal; the output register reloads with no bubble.
- out_inst and out_addr stay stable while out_valid && !out_ready.
- Reset values: out_valid=0, out_inst=0, out_addr=0, busy=0, done=0, err=0, in_ready=0, state=IDLE, pc=0.
- rst mid-batch drops any pending word immediately, and done is not pulsed.
- A batch of exactly one word goes RUN -> DRAIN in one accept; done follows the cycle after that word is drained.

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - I and S formats set err when in_imm is outside [-2048, 2047].
  - B format sets err when in_imm is outside [-4096, 4094] or in_imm[0] is 1.
  - The word is still emitted with the immediate truncated.
- IMM_RANGE_CHECK_EN undefined:
  - The immediate is truncated silently.
  - err is raised only by an undefined in_fmt.

## Structure
- riscv_pkg holds:
  - fmt_e enum.
  - Opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - NOP_INST constant.
- Sub-module inst_pack: purely combinational; maps fields to a 32-bit word plus a range_err flag.
- inst_encoder holds the FSM, pc, output register and handshake.

## Test plan
- addi x1,x0,5 (I_ALU, f3=0, imm=5), base_addr=0x100 -> out_inst=0x00500093, out_addr=0x100.
- Stream lw x2,8(x1); sw x2,12(x1); add x3,x1,x2 with out_ready=1 -> 0x0080A103, 0x0020A623, 0x002081B3 on back-to-back cycles at addresses 0x0, 0x4, 0x8.
- beq x1,x2,-8 marked in_last -> 0xFE208CE3; done pulses once the word drains; then busy=0.
- Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, out_* stable, no word lost or duplicated.
- addi imm=4096, and B imm=5 with IMM_RANGE_CHECK_EN defined -> err=1 (sticky until next start). Without the macro -> err=0.
- in_fmt=7 -> out_inst=0x00000013, err=1. Separately, rst asserted in RUN -> all outputs return to reset values next cycle.
